// File: rtl/mem2_load_stage_if.sv
// MEM -> MEM2 handshake bundle: pipeline control, MEM-stage fields, dcache read response and MEM2 outputs.
// slave is the MEM2 stage itself; master is whatever drives it (pipeline or bench).
interface mem2_load_stage_if;
    logic        MEM2_Flush;
    logic        MEM2_Wr;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_ALUOut;
    logic [31:0] MEM_Result;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegWr;
    logic        MEM_LoadEn;
    logic        MEM_LoadSign;
    logic [1:0]  MEM_LoadSize;
    logic        MEM_ReqIssued;
    logic        dbus_rdata_valid;
    logic [31:0] dbus_rdata;
    logic [31:0] MEM2_PC;
    logic [4:0]  MEM2_Dst;
    logic        MEM2_RegWr;
    logic [31:0] MEM2_Result;
    logic        MEM2_ResultValid;
    logic        MEM2_StallReq;

    modport slave (
        input  MEM2_Flush, MEM2_Wr, MEM_PC, MEM_ALUOut, MEM_Result, MEM_Dst, MEM_RegWr,
               MEM_LoadEn, MEM_LoadSign, MEM_LoadSize, MEM_ReqIssued,
               dbus_rdata_valid, dbus_rdata,
        output MEM2_PC, MEM2_Dst, MEM2_RegWr, MEM2_Result, MEM2_ResultValid, MEM2_StallReq
    );

    modport master (
        output MEM2_Flush, MEM2_Wr, MEM_PC, MEM_ALUOut, MEM_Result, MEM_Dst, MEM_RegWr,
               MEM_LoadEn, MEM_LoadSign, MEM_LoadSize, MEM_ReqIssued,
               dbus_rdata_valid, dbus_rdata,
        input  MEM2_PC, MEM2_Dst, MEM2_RegWr, MEM2_Result, MEM2_ResultValid, MEM2_StallReq
    );
endinterface

// File: rtl/mem2_load_stage.sv
// MEM2 stage: holds the MEM/MEM2 register, tracks the outstanding dcache load and aligns/extends its data.
// Non-load result valid 1 cycle after capture, load 1 cycle after rdata; stall requested while a response is outstanding.
module mem2_load_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem2_load_stage_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    typedef struct packed {
        logic [1:0] off;
        logic       sign;
        logic [1:0] size;
    } ld_meta_t;

    state_t                state_q;
    ld_meta_t              meta_q;
    logic [31:0]           pc_q;
    logic [4:0]            dst_q;
    logic                  regwr_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  rvalid_q;

    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_data_d;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.MEM_ALUOut[31:2];

    always_comb begin
        byte_lane   = bus.dbus_rdata[{meta_q.off, 3'b000} +: 8];
        half_lane   = meta_q.off[1] ? bus.dbus_rdata[31:16] : bus.dbus_rdata[15:0];
        load_data_d = bus.dbus_rdata;
        case (meta_q.size)
            2'b00:   load_data_d = {{(DATA_WIDTH-8){meta_q.sign & byte_lane[7]}}, byte_lane};
            2'b01:   load_data_d = {{(DATA_WIDTH-16){meta_q.sign & half_lane[15]}}, half_lane};
            default: load_data_d = bus.dbus_rdata;
        endcase
    end

    // Stage only accepts new work in IDLE; in WAIT/DRAIN the response owns the cycle it arrives in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            meta_q   <= '0;
            pc_q     <= PC_RESET;
            dst_q    <= '0;
            regwr_q  <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
        end else if (bus.MEM2_Flush) begin
            meta_q   <= '0;
            dst_q    <= '0;
            regwr_q  <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            if (state_q == S_WAIT)
                state_q <= bus.dbus_rdata_valid ? S_IDLE : S_DRAIN;
            else if (state_q == S_DRAIN && bus.dbus_rdata_valid)
                state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.MEM2_Wr) begin
                        pc_q     <= bus.MEM_PC;
                        dst_q    <= bus.MEM_Dst;
                        result_q <= bus.MEM_Result;
                        meta_q   <= '{off: bus.MEM_ALUOut[1:0], sign: bus.MEM_LoadSign,
                                      size: bus.MEM_LoadSize};
                        if (bus.MEM_LoadEn && bus.MEM_ReqIssued) begin
                            regwr_q  <= bus.MEM_RegWr;
                            rvalid_q <= 1'b0;
                            state_q  <= S_WAIT;
                        end else begin
                            // A load the dcache never accepted must not write back.
                            regwr_q  <= bus.MEM_RegWr & ~bus.MEM_LoadEn;
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dbus_rdata_valid) begin
                        result_q <= load_data_d;
                        rvalid_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (bus.dbus_rdata_valid)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.MEM2_PC          = pc_q;
    assign bus.MEM2_Dst         = dst_q;
    assign bus.MEM2_RegWr       = regwr_q;
    assign bus.MEM2_Result      = result_q;
    assign bus.MEM2_ResultValid = rvalid_q;
    assign bus.MEM2_StallReq    = (state_q != S_IDLE) && !bus.dbus_rdata_valid;

endmodule

// File: tb/tb_mem2_load_stage.sv
// Bench for mem2_load_stage: directed cases plus random traffic against a queue-based reference model.
module tb_mem2_load_stage;
    localparam logic [31:0] PCR = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem2_load_stage_if bus();
    mem2_load_stage #(.PC_RESET(PCR), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc, m_result;
    logic [4:0]  m_dst;
    logic        m_regwr, m_valid;
    bit          m_res_known, m_valid_known;
    bit          pend_q[$];   // 1 = response belongs to a live load, 0 = to be drained
    int          m_off, m_size;
    bit          m_sign;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] extract(input int off, input int size, input bit sign,
                                            input logic [31:0] w);
        int unsigned v;
        if (size == 0) begin
            v = (w >> (8 * off)) & 32'hFF;
            return (sign && v >= 128) ? 32'(v) - 32'd256 : 32'(v);
        end else if (size == 1) begin
            v = (w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            return (sign && v >= 32768) ? 32'(v) - 32'd65536 : 32'(v);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_pc = PCR; m_result = '0; m_dst = '0; m_regwr = 1'b0; m_valid = 1'b0;
        m_res_known = 1; m_valid_known = 1;
        m_off = 0; m_size = 0; m_sign = 0;
        pend_q.delete();
    endtask

    task automatic model_clock();
        if (bus.MEM2_Flush) begin
            m_dst = '0; m_regwr = 1'b0; m_result = '0; m_valid = 1'b0;
            m_res_known = 1; m_valid_known = 1;
            if (pend_q.size() != 0) begin
                if (bus.dbus_rdata_valid) void'(pend_q.pop_front());
                else pend_q[0] = 0;
            end
        end else if (pend_q.size() != 0) begin
            if (bus.dbus_rdata_valid) begin
                if (pend_q[0]) begin
                    m_result = extract(m_off, m_size, m_sign, bus.dbus_rdata);
                    m_valid = 1'b1; m_res_known = 1; m_valid_known = 1;
                end
                void'(pend_q.pop_front());
            end
        end else if (bus.MEM2_Wr) begin
            m_pc = bus.MEM_PC; m_dst = bus.MEM_Dst;
            m_off = int'(bus.MEM_ALUOut[1:0]); m_size = int'(bus.MEM_LoadSize);
            m_sign = bus.MEM_LoadSign;
            if (bus.MEM_LoadEn && bus.MEM_ReqIssued) begin
                m_regwr = bus.MEM_RegWr; m_valid = 1'b0;
                m_res_known = 0; m_valid_known = 1;
                pend_q.push_back(1);
            end else if (bus.MEM_LoadEn) begin
                m_regwr = 1'b0; m_res_known = 0; m_valid_known = 0;
            end else begin
                m_regwr = bus.MEM_RegWr; m_result = bus.MEM_Result; m_valid = 1'b1;
                m_res_known = 1; m_valid_known = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_pc"}, bus.MEM2_PC, m_pc);
        chk({tag, "_dst"}, 32'(bus.MEM2_Dst), 32'(m_dst));
        chk({tag, "_regwr"}, 32'(bus.MEM2_RegWr), 32'(m_regwr));
        if (m_valid_known) chk({tag, "_valid"}, 32'(bus.MEM2_ResultValid), 32'(m_valid));
        if (m_res_known) chk({tag, "_result"}, bus.MEM2_Result, m_result);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        last_stall = bus.MEM2_StallReq;
        chk({tag, "_stall"}, 32'(bus.MEM2_StallReq),
            32'((pend_q.size() != 0) && !bus.dbus_rdata_valid));
        @(posedge clk);
        model_clock();
        #1;
        check_outputs(tag);
    endtask

    task automatic clear_in();
        bus.MEM2_Flush = 0; bus.MEM2_Wr = 0; bus.MEM_PC = '0; bus.MEM_ALUOut = '0;
        bus.MEM_Result = '0; bus.MEM_Dst = '0; bus.MEM_RegWr = 0; bus.MEM_LoadEn = 0;
        bus.MEM_LoadSign = 0; bus.MEM_LoadSize = '0; bus.MEM_ReqIssued = 0;
        bus.dbus_rdata_valid = 0; bus.dbus_rdata = '0;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] res,
                          input logic [4:0] dst, input bit regwr, input bit ld, input bit sgn,
                          input logic [1:0] size, input bit req);
        clear_in();
        bus.MEM2_Wr = 1; bus.MEM_PC = pc; bus.MEM_ALUOut = alu; bus.MEM_Result = res;
        bus.MEM_Dst = dst; bus.MEM_RegWr = regwr; bus.MEM_LoadEn = ld;
        bus.MEM_LoadSign = sgn; bus.MEM_LoadSize = size; bus.MEM_ReqIssued = req;
    endtask

    task automatic run_load(input string tag, input logic [31:0] alu, input bit sgn,
                            input logic [1:0] size, input logic [31:0] w, input int gap,
                            input logic [31:0] expv);
        int hi;
        hi = 0;
        set_op(32'h0000_2000 + alu, alu, 32'h5555_AAAA, 5'd9, 1, 1, sgn, size, 1);
        step({tag, "_cap"});
        clear_in();
        chk({tag, "_valid0"}, 32'(bus.MEM2_ResultValid), 32'd0);
        for (int i = 0; i < gap; i++) begin
            step({tag, "_wait"});
            if (last_stall) hi++;
        end
        bus.dbus_rdata_valid = 1; bus.dbus_rdata = w;
        step({tag, "_rd"});
        chk({tag, "_stall_drop"}, 32'(last_stall), 32'd0);
        clear_in();
        chk({tag, "_res"}, bus.MEM2_Result, expv);
        chk({tag, "_valid1"}, 32'(bus.MEM2_ResultValid), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(hi), 32'(gap));
    endtask

    initial begin
        rst = 1;
        clear_in();
        model_reset();
        #12;
        chk("rst_pc", bus.MEM2_PC, PCR);
        chk("rst_result", bus.MEM2_Result, 32'd0);
        chk("rst_valid", 32'(bus.MEM2_ResultValid), 32'd0);
        chk("rst_stall", 32'(bus.MEM2_StallReq), 32'd0);
        chk("rst_regwr", 32'(bus.MEM2_RegWr), 32'd0);
        @(negedge clk);
        rst = 0;

        set_op(32'h0000_1000, 32'h0, 32'h1234_5678, 5'd5, 1, 0, 0, 2'b00, 0);
        step("nl");
        clear_in();
        chk("nl_res", bus.MEM2_Result, 32'h1234_5678);
        chk("nl_valid", 32'(bus.MEM2_ResultValid), 32'd1);
        chk("nl_dst", 32'(bus.MEM2_Dst), 32'd5);
        step("nl_idle");
        chk("nl_stall", 32'(last_stall), 32'd0);

        run_load("lb", 32'h1000_0002, 1, 2'b00, 32'h0080_1122, 3, 32'hFFFF_FF80);
        run_load("lhu", 32'h1000_0006, 0, 2'b01, 32'hBEEF_0001, 1, 32'h0000_BEEF);
        run_load("lw", 32'h1000_0008, 0, 2'b10, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        run_load("lbu0", 32'h1000_0000, 0, 2'b00, 32'h0000_00F3, 2, 32'h0000_00F3);
        run_load("lh_lo", 32'h1000_0000, 1, 2'b01, 32'h1234_8001, 1, 32'hFFFF_8001);

        set_op(32'h0000_3000, 32'h4, 32'h0, 5'd3, 1, 1, 0, 2'b10, 0);
        step("cancel");
        clear_in();
        chk("cancel_regwr", 32'(bus.MEM2_RegWr), 32'd0);
        step("cancel_idle");
        chk("cancel_stall", 32'(last_stall), 32'd0);

        set_op(32'h0000_4000, 32'h8, 32'h0, 5'd4, 1, 1, 0, 2'b10, 1);
        step("fl_cap");
        clear_in();
        step("fl_wait");
        bus.MEM2_Flush = 1;
        step("fl_flush");
        clear_in();
        chk("fl_regwr", 32'(bus.MEM2_RegWr), 32'd0);
        chk("fl_res", bus.MEM2_Result, 32'd0);
        step("fl_drain");
        chk("fl_drain_stall", 32'(last_stall), 32'd1);
        bus.dbus_rdata_valid = 1; bus.dbus_rdata = 32'hDEAD_BEEF;
        step("fl_pulse");
        clear_in();
        chk("fl_res_after", bus.MEM2_Result, 32'd0);
        chk("fl_valid_after", 32'(bus.MEM2_ResultValid), 32'd0);
        step("fl_idle");
        chk("fl_idle_stall", 32'(last_stall), 32'd0);

        set_op(32'h0000_5000, 32'hC, 32'h0, 5'd6, 1, 1, 1, 2'b00, 1);
        step("fc_cap");
        clear_in();
        bus.MEM2_Flush = 1; bus.dbus_rdata_valid = 1; bus.dbus_rdata = 32'h7777_7777;
        step("fc_both");
        clear_in();
        chk("fc_res", bus.MEM2_Result, 32'd0);
        step("fc_idle");
        chk("fc_stall", 32'(last_stall), 32'd0);

        set_op(32'h0000_6000, 32'h10, 32'h0, 5'd8, 1, 1, 0, 2'b10, 1);
        step("rw_cap");
        clear_in();
        step("rw_wait");
        rst = 1;
        #2;
        model_reset();
        chk("rw_pc", bus.MEM2_PC, PCR);
        chk("rw_stall", 32'(bus.MEM2_StallReq), 32'd0);
        chk("rw_regwr", 32'(bus.MEM2_RegWr), 32'd0);
        #1;
        rst = 0;
        bus.dbus_rdata_valid = 1; bus.dbus_rdata = 32'h1111_2222;
        step("rw_late");
        clear_in();
        chk("rw_late_res", bus.MEM2_Result, 32'd0);
        chk("rw_late_valid", 32'(bus.MEM2_ResultValid), 32'd0);
        chk("rw_late_pc", bus.MEM2_PC, PCR);

        for (int it = 0; it < 500; it++) begin
            clear_in();
            bus.MEM_PC = $urandom; bus.MEM_ALUOut = $urandom; bus.MEM_Result = $urandom;
            bus.MEM_Dst = 5'($urandom); bus.MEM_RegWr = 1'($urandom);
            bus.MEM_LoadEn = 1'($urandom); bus.MEM_LoadSign = 1'($urandom);
            bus.MEM_LoadSize = 2'($urandom_range(0, 2));
            bus.MEM_ReqIssued = ($urandom_range(0, 3) != 0);
            bus.dbus_rdata = $urandom;
            if (pend_q.size() == 0) begin
                bus.MEM2_Wr = ($urandom_range(0, 9) < 7);
                bus.dbus_rdata_valid = ($urandom_range(0, 3) == 0);
            end else begin
                bus.dbus_rdata_valid = ($urandom_range(0, 2) == 0);
                bus.MEM2_Wr = bus.dbus_rdata_valid ? 1'b0 : 1'($urandom);
            end
            bus.MEM2_Flush = ($urandom_range(0, 9) == 0);
            step("rnd");
        end
        clear_in();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem2_load_stage.md
Name: mem2_load_stage

Overview:
- Sits directly downstream of the MEM stage and holds the MEM/MEM2 pipeline register.
- Tracks the outstanding data-cache load issued in MEM and captures the dcache read response.
- Aligns and sign/zero-extends the loaded data, and produces the MEM2 writeback result.
- Raises a stall request while a load response is outstanding, including responses belonging to flushed loads that must be drained.

Parameters:
- PC_RESET, 32'h0000_0000, reset value of MEM2_PC.
- DATA_WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- MEM2_Flush  in  1  clear stage (exception/refetch).
- MEM2_Wr  in  1  stage write enable (0 = hold).
- MEM_PC  in  32  PC of the MEM instruction.
- MEM_ALUOut  in  32  virtual data address; bits [1:0] select the byte lane.
- MEM_Result  in  32  non-load result from MEM.
- MEM_Dst  in  5  destination GPR.
- MEM_RegWr  in  1  GPR write enable (already DisWr-gated).
- MEM_LoadEn  in  1  instruction is a load.
- MEM_LoadSign  in  1  1 = sign-extend, 0 = zero-extend.
- MEM_LoadSize  in  2  00 byte, 01 half, 10 word.
- MEM_ReqIssued  in  1  the dcache accepted the MEM load request this cycle.
- dbus_rdata_valid  in  1  dcache read data valid (one-cycle pulse).
- dbus_rdata  in  32  dcache read word.
- MEM2_PC  out  32  registered PC.
- MEM2_Dst  out  5  registered destination.
- MEM2_RegWr  out  1  registered write enable.
- MEM2_Result  out  32  final writeback data.
- MEM2_ResultValid  out  1  MEM2_Result is final (used by forwarding).
- MEM2_StallReq  out  1  stall request to the hazard unit.

Behaviour:
- Reset:
  - state = IDLE.
  - MEM2_PC = PC_RESET.
  - All other outputs = 0.
  - The internal address-offset, load-type and data registers = 0.
- Pipeline register update:
  - If MEM2_Flush = 1, clear Dst, RegWr, Result, the load fields and ResultValid. Flush has priority over MEM2_Wr.
  - Else if MEM2_Wr = 1, capture all MEM_* inputs.
  - Else hold.
- States:
  - IDLE: no outstanding response.
  - WAIT: own load outstanding.
  - DRAIN: a flushed load's response is still outstanding.
- Transitions:
  - IDLE -> WAIT on a capture with MEM_LoadEn & MEM_ReqIssued.
  - IDLE -> IDLE on any other capture. A load captured without MEM_ReqIssued is excepted or cancelled: set RegWr = 0.
  - WAIT -> IDLE on dbus_rdata_valid with no flush.
  - WAIT -> DRAIN on MEM2_Flush without dbus_rdata_valid.
  - WAIT -> IDLE on MEM2_Flush together with dbus_rdata_valid; the data is discarded.
  - DRAIN -> IDLE on dbus_rdata_valid; the data is discarded and no register changes.
  - dbus_rdata_valid seen in IDLE is ignored.
- MEM2_StallReq = 1 in WAIT and DRAIN, combinationally cleared in the cycle dbus_rdata_valid is high.
- The hazard unit keeps MEM2_Wr = 0 while StallReq is high. A MEM2_Wr received in WAIT/DRAIN without rdata_valid is ignored (registers hold).
- Result capture in WAIT on dbus_rdata_valid, aligned with off = ALUOut[1:0] and written into the MEM2_Result register:
  - byte: dbus_rdata[8*off+7 : 8*off], extended to 32 bits.
  - half: lane (off[1] ? [31:16] : [15:0]), extended to 32 bits.
  - word: dbus_rdata unchanged.
  - Misaligned offsets never arrive here (trapped in MEM); the lane is still selected by the off bits with no error.
- MEM2_ResultValid:
  - Set to 1 on a non-load capture (Result = MEM_Result).
  - Set to 0 on a load capture that enters WAIT.
  - Set to 1 in the cycle after rdata capture.
- Latency:
  - Load result is valid 1 cycle after dbus_rdata_valid.
  - Non-load result is valid 1 cycle after capture.
- Reset mid-operation: returns to IDLE immediately, and any late rdata_valid is ignored.

Test Plan:
- Non-load: MEM_Result = 32'h1234_5678, Dst = 5, RegWr = 1, Wr = 1 -> next cycle Result = 32'h1234_5678, ResultValid = 1, StallReq = 0.
- LB, sign, off = 2, ReqIssued = 1; rdata_valid 3 cycles later with 32'h00_80_11_22 -> StallReq = 1 for 3 cycles, drops the same cycle as rdata_valid; next cycle Result = 32'hFFFF_FF80, ResultValid = 1.
- LHU, off = 2, rdata = 32'hBEEF_0001 -> 32'h0000_BEEF; LW, rdata = 32'hCAFE_F00D -> 32'hCAFE_F00D.
- Load in WAIT, flush 1 cycle later, rdata_valid 2 cycles after that -> DRAIN, StallReq held, RegWr = 0, Result unchanged (0), IDLE after the pulse.
- Flush coincident with rdata_valid in WAIT -> IDLE directly, data dropped, StallReq = 0 next cycle.
- rst asserted in WAIT, then rdata_valid after release -> outputs 0, MEM2_PC = PC_RESET, pulse ignored, StallReq = 0.
